// File: rtl/inv_transcr.sv
// Inverse nonlinear Cr transform: recovers Cr from transformed Cr, luma and mean/width LUT values.
// One pixel in flight; bypass inside the luma window, otherwise a serial restoring divide.
module inv_transcr #(
  parameter int unsigned K_L     = 125,
  parameter int unsigned K_H     = 188,
  parameter int unsigned MKH     = 154,
  parameter int unsigned W_WIDTH = 16,
  parameter int unsigned FRAC    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         t_in,
  input  logic [7:0]         y_in,
  input  logic [7:0]         mean_in,
  input  logic [W_WIDTH-1:0] width_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         cr_out,
  output logic               bypass,
  output logic               div0
);

  localparam int unsigned DW = 9 + FRAC;  // signed (t - MKH) << FRAC
  localparam int unsigned MW = DW - 1;    // magnitude width == divide iterations
  localparam int unsigned CW = $clog2(MW + 1);
  localparam int unsigned RW = MW + 2;    // signed result width

  localparam logic [7:0] KLo = 8'(K_L);
  localparam logic [7:0] KHi = 8'(K_H);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StByp  = 3'd1;
  localparam logic [2:0] StPrep = 3'd2;
  localparam logic [2:0] StDiv  = 3'd3;
  localparam logic [2:0] StFix  = 3'd4;
  localparam logic [2:0] StOut  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [7:0]         t_q, m_q;
  logic [W_WIDTH-1:0] w_q;
  logic               sign_q, dnz_q;
  logic [MW-1:0]      quo_q;
  logic [W_WIDTH-1:0] rem_q;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         cr_q;
  logic               byp_q, div0_q;

  logic               accept, in_window;
  logic signed [DW-1:0] d_val;
  logic [MW-1:0]      d_mag;
  logic [W_WIDTH:0]   rem_sh, rem_sub;
  logic               ge;
  logic signed [RW-1:0] q_s, r_s;
  logic [7:0]         r_clamp, fix_cr;

  assign accept    = in_valid && (state_q == StIdle);
  assign in_window = (y_in >= KLo) && (y_in <= KHi);

  assign d_val = ($signed({{(DW-8){1'b0}}, t_q}) - $signed(DW'(MKH))) <<< FRAC;
  assign d_mag = d_val[DW-1] ? MW'(-d_val) : d_val[MW-1:0];

  // One restoring step: shift in the next dividend bit, subtract W when it fits.
  assign rem_sh  = {rem_q, quo_q[MW-1]};
  assign ge      = rem_sh >= {1'b0, w_q};
  assign rem_sub = rem_sh - {1'b0, w_q};

  assign q_s = sign_q ? -$signed({2'b00, quo_q}) : $signed({2'b00, quo_q});
  assign r_s = $signed({{(RW-8){1'b0}}, m_q}) + q_s;

  always_comb begin
    r_clamp = r_s[7:0];
    if (r_s < 0)                  r_clamp = 8'd0;
    else if (r_s > RW'(signed'(255))) r_clamp = 8'd255;
    fix_cr = r_clamp;
    if (w_q == '0) begin
      if (!dnz_q)     fix_cr = m_q;
      else if (sign_q) fix_cr = 8'd0;
      else            fix_cr = 8'd255;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = in_window ? StByp : StPrep;
      StByp:  state_d = StOut;
      StPrep: state_d = StDiv;
      // Final DIV cycle (cnt == MW) is idle so the divide path lands at latency 19.
      StDiv:  if (cnt_q == CW'(MW)) state_d = StFix;
      StFix:  state_d = StOut;
      StOut:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      sign_q  <= 1'b0;
      dnz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      cr_q    <= '0;
      byp_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: if (accept) begin
          t_q    <= t_in;
          m_q    <= mean_in;
          w_q    <= width_in;
          byp_q  <= 1'b0;
          div0_q <= 1'b0;
        end
        StByp: begin
          cr_q  <= t_q;
          byp_q <= 1'b1;
        end
        StPrep: begin
          quo_q  <= d_mag;
          rem_q  <= '0;
          sign_q <= d_val[DW-1];
          dnz_q  <= (d_val != '0);
          cnt_q  <= '0;
        end
        StDiv: if (cnt_q != CW'(MW)) begin
          rem_q <= ge ? rem_sub[W_WIDTH-1:0] : rem_sh[W_WIDTH-1:0];
          quo_q <= {quo_q[MW-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
        end
        StFix: begin
          cr_q   <= fix_cr;
          div0_q <= (w_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign cr_out    = cr_q;
  assign bypass    = byp_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_inv_transcr.sv
// Directed bench for inv_transcr: hand-computed vectors, latency, hold/handshake and reset abort.
module tb_inv_transcr;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, bypass, div0;
  logic [7:0]  t_in, y_in, mean_in, cr_out;
  logic [15:0] width_in;

  int errs   = 0;
  int checks = 0;

  inv_transcr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .t_in     (t_in),
    .y_in     (y_in),
    .mean_in  (mean_in),
    .width_in (width_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cr_out   (cr_out),
    .bypass   (bypass),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  y, t, m;
    logic [15:0] w;
    logic [7:0]  cr;
    logic        byp, d0;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [7:0] y, t, m, input logic [15:0] w);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    y_in = y; t_in = t; mean_in = m; width_in = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the block must have registered them at the accept edge.
    y_in = 8'($urandom); t_in = 8'($urandom); mean_in = 8'($urandom); width_in = 16'($urandom);
  endtask

  task automatic expect_res(input string tag, input logic [7:0] cr, input logic byp, d0,
                            input int lat, input int hold);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_cr"}, 32'(cr_out), 32'(cr));
    check({tag, "_bypass"}, 32'(bypass), 32'(byp));
    check({tag, "_div0"}, 32'(div0), 32'(d0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; y_in = 8'd150; t_in = 8'd3;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_cr"}, 32'(cr_out), 32'(cr));
      check({tag, "_hold_flags"}, {30'd0, bypass, div0}, {30'd0, byp, d0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{y: 150, t: 200, m: 0,   w: 0,   cr: 200, byp: 1, d0: 0};
    vecs[1]  = '{y: 50,  t: 170, m: 140, w: 512, cr: 148, byp: 0, d0: 0};
    vecs[2]  = '{y: 220, t: 100, m: 150, w: 256, cr: 96,  byp: 0, d0: 0};
    vecs[3]  = '{y: 50,  t: 153, m: 100, w: 768, cr: 100, byp: 0, d0: 0};
    vecs[4]  = '{y: 30,  t: 255, m: 250, w: 128, cr: 255, byp: 0, d0: 0};
    vecs[5]  = '{y: 30,  t: 0,   m: 10,  w: 128, cr: 0,   byp: 0, d0: 0};
    vecs[6]  = '{y: 30,  t: 200, m: 90,  w: 0,   cr: 255, byp: 0, d0: 1};
    vecs[7]  = '{y: 30,  t: 154, m: 90,  w: 0,   cr: 90,  byp: 0, d0: 1};
    vecs[8]  = '{y: 30,  t: 100, m: 90,  w: 0,   cr: 0,   byp: 0, d0: 1};
    vecs[9]  = '{y: 50,  t: 170, m: 100, w: 300, cr: 113, byp: 0, d0: 0};
    vecs[10] = '{y: 50,  t: 140, m: 100, w: 300, cr: 89,  byp: 0, d0: 0};
    vecs[11] = '{y: 124, t: 154, m: 77,  w: 256, cr: 77,  byp: 0, d0: 0};
    vecs[12] = '{y: 125, t: 7,   m: 9,   w: 5,   cr: 7,   byp: 1, d0: 0};
    vecs[13] = '{y: 188, t: 250, m: 9,   w: 5,   cr: 250, byp: 1, d0: 0};
    vecs[14] = '{y: 189, t: 154, m: 33,  w: 10,  cr: 33,  byp: 0, d0: 0};
    vecs[15] = '{y: 50,  t: 160, m: 0,   w: 1,   cr: 255, byp: 0, d0: 0};
    vecs[16] = '{y: 150, t: 201, m: 5,   w: 0,   cr: 201, byp: 1, d0: 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    t_in = '0; y_in = '0; mean_in = '0; width_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outs", {22'd0, cr_out, bypass, div0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].y, vecs[i].t, vecs[i].m, vecs[i].w);
      expect_res($sformatf("vec%0d", i), vecs[i].cr, vecs[i].byp, vecs[i].d0,
                 vecs[i].byp ? 1 : 19, 0);
    end

    // Back-pressure: result and flags hold, extra requests dropped.
    send(8'd150, 8'd200, 8'd0, 16'd0);
    expect_res("hold_byp", 8'd200, 1'b1, 1'b0, 1, 10);
    send(8'd30, 8'd200, 8'd90, 16'd0);
    expect_res("hold_div0", 8'd255, 1'b0, 1'b1, 19, 10);
    @(posedge clk); #1;
    check("idle_after_drop", 32'(out_valid), 32'd0);

    // Reset during DIV aborts the pixel immediately.
    send(8'd50, 8'd170, 8'd140, 16'd512);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_cr", 32'(cr_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd220, 8'd100, 8'd150, 16'd256);
    expect_res("after_abort", 8'd96, 1'b0, 1'b0, 19, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
